// File: rtl/im_bus_fetch_ctrl.sv
// Instruction fetch controller. Issues sequential instruction reads on an
// AXI-style AR/R pair, keeps up to MAX_OUT reads in flight, drops stale beats
// after a redirect and hands instructions to decode via a one-entry register.
//
// state  | meaning
// IDLE   | no new reads; stray responses are accepted and dropped
// RUN    | issuing sequential fetches while fewer than MAX_OUT are in flight
// DRAIN  | halted; no new reads, waiting for in-flight reads to return

module im_bus_fetch_ctrl #(
    parameter int ALEN = 32,
    parameter int DLEN = 32,
    parameter int IDLEN = 4,
    parameter int MAX_OUT = 2,
    parameter logic [ALEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_halt,
    input  logic             i_redirect,
    input  logic [ALEN-1:0]  i_redirect_pc,
    output logic             o_im_bus_arvalid,
    input  logic             i_im_bus_arready,
    output logic [ALEN-1:0]  o_im_bus_araddr,
    output logic [2:0]       o_im_bus_arprot,
    output logic [IDLEN-1:0] o_im_bus_arid,
    input  logic             i_im_bus_rvalid,
    output logic             o_im_bus_rready,
    input  logic [DLEN-1:0]  i_im_bus_rdata,
    input  logic [1:0]       i_im_bus_rresp,
    input  logic [IDLEN-1:0] i_im_bus_rid,
    output logic             o_inst_valid,
    input  logic             i_inst_ready,
    output logic [DLEN-1:0]  o_inst,
    output logic [ALEN-1:0]  o_inst_pc,
    output logic             o_inst_err,
    output logic             o_busy,
    output logic             o_id_err
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             arvalid_q, arvalid_d;
    logic [ALEN-1:0]  araddr_q, araddr_d;
    logic [ALEN-1:0]  fetch_pc_q, fetch_pc_d, fetch_pc_n;
    logic [IDLEN-1:0] arid_q, arid_d, next_id_q, next_id_d, exp_id_q, exp_id_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d, disc_q, disc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             inst_valid_q, inst_valid_d;
    logic [DLEN-1:0]  inst_q, inst_d;
    logic [ALEN-1:0]  inst_pc_q, inst_pc_d;
    logic             inst_err_q, inst_err_d;
    logic             id_err_q, id_err_d;
    logic [ALEN-1:0]  pc_mem_q [MAX_OUT];

    logic ar_hs, ar_pend, r_hs, spurious, discard, real_beat, rready;

    // A beat with nothing outstanding (e.g. after reset) is swallowed silently.
    assign ar_hs     = arvalid_q && i_im_bus_arready;
    assign ar_pend   = arvalid_q && !i_im_bus_arready;
    assign spurious  = (out_cnt_q == '0);
    assign discard   = (disc_q != '0) || spurious;
    assign rready    = rstn && (discard || !inst_valid_q || i_inst_ready);
    assign r_hs      = i_im_bus_rvalid && rready;
    assign real_beat = r_hs && !spurious;

    // Next-state logic for sequencing, AR issue, flush accounting and output register.
    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arid_d       = arid_q;
        next_id_d    = next_id_q;
        exp_id_d     = exp_id_q + IDLEN'(real_beat);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        disc_d       = disc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_err_d   = inst_err_q;
        id_err_d     = id_err_q;

        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (i_halt) state_d = S_DRAIN;
            S_DRAIN: begin
                if (i_start) state_d = S_RUN;
                else if (spurious && !arvalid_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        out_cnt_d = out_cnt_q + CNT_W'(ar_hs) - CNT_W'(real_beat);

        if (ar_hs) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (real_beat) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

        // A presented AR is never withdrawn or altered; a redirect only retargets the next one.
        fetch_pc_n = i_redirect ? i_redirect_pc : fetch_pc_q;
        fetch_pc_d = fetch_pc_n;
        if (!ar_pend) begin
            if (state_d == S_RUN && out_cnt_d < MAX_CNT) begin
                arvalid_d  = 1'b1;
                araddr_d   = fetch_pc_n;
                arid_d     = next_id_q;
                fetch_pc_d = fetch_pc_n + ALEN'(4);
                next_id_d  = next_id_q + 1'b1;
            end else begin
                arvalid_d = 1'b0;
            end
        end

        if (real_beat && i_im_bus_rid != exp_id_q) id_err_d = 1'b1;

        // Everything already issued, including a still-pending AR, belongs to the old stream.
        if (i_redirect) disc_d = out_cnt_d + CNT_W'(ar_pend);
        else if (real_beat && disc_q != '0) disc_d = disc_q - 1'b1;

        if (i_redirect) begin
            inst_valid_d = 1'b0;
        end else if (r_hs && !discard) begin
            inst_valid_d = 1'b1;
            inst_d       = i_im_bus_rdata;
            inst_pc_d    = pc_mem_q[rd_ptr_q];
            inst_err_d   = (i_im_bus_rresp != 2'b00);
        end else if (i_inst_ready) begin
            inst_valid_d = 1'b0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arid_q       <= '0;
            fetch_pc_q   <= RESET_PC;
            next_id_q    <= '0;
            exp_id_q     <= '0;
            out_cnt_q    <= '0;
            disc_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
            id_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arid_q       <= arid_d;
            fetch_pc_q   <= fetch_pc_d;
            next_id_q    <= next_id_d;
            exp_id_q     <= exp_id_d;
            out_cnt_q    <= out_cnt_d;
            disc_q       <= disc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
            id_err_q     <= id_err_d;
        end
    end

    // PC of each accepted read, consumed in order as beats return.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_OUT; i++) pc_mem_q[i] <= '0;
        end else if (ar_hs) begin
            pc_mem_q[wr_ptr_q] <= araddr_q;
        end
    end

    assign o_im_bus_arvalid = arvalid_q;
    assign o_im_bus_araddr  = araddr_q;
    assign o_im_bus_arid    = arid_q;
    assign o_im_bus_arprot  = 3'b100;
    assign o_im_bus_rready  = rready;
    assign o_inst_valid     = inst_valid_q;
    assign o_inst           = inst_q;
    assign o_inst_pc        = inst_pc_q;
    assign o_inst_err       = inst_err_q;
    assign o_busy           = !spurious;
    assign o_id_err         = id_err_q;

endmodule

// File: tb/tb_im_bus_fetch_ctrl.sv
// Bench for im_bus_fetch_ctrl: in-order memory responder plus a scoreboard of
// expected instructions, exercised through one task per scenario.

module tb_im_bus_fetch_ctrl;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_start = 0, i_halt = 0, i_redirect = 0;
    logic [31:0] i_redirect_pc = '0;
    logic o_arvalid, i_arready = 0;
    logic [31:0] o_araddr;
    logic [2:0] o_arprot;
    logic [3:0] o_arid;
    logic i_rvalid = 0, o_rready;
    logic [31:0] i_rdata = '0;
    logic [1:0] i_rresp = '0;
    logic [3:0] i_rid = '0;
    logic o_inst_valid, i_inst_ready = 0;
    logic [31:0] o_inst, o_inst_pc;
    logic o_inst_err, o_busy, o_id_err;

    im_bus_fetch_ctrl #(.ALEN(32), .DLEN(32), .IDLEN(4), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_halt(i_halt),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_im_bus_arvalid(o_arvalid), .i_im_bus_arready(i_arready),
        .o_im_bus_araddr(o_araddr), .o_im_bus_arprot(o_arprot), .o_im_bus_arid(o_arid),
        .i_im_bus_rvalid(i_rvalid), .o_im_bus_rready(o_rready), .i_im_bus_rdata(i_rdata),
        .i_im_bus_rresp(i_rresp), .i_im_bus_rid(i_rid),
        .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready), .o_inst(o_inst),
        .o_inst_pc(o_inst_pc), .o_inst_err(o_inst_err), .o_busy(o_busy), .o_id_err(o_id_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] id; } ar_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;

    ar_t         resp_q[$];
    exp_t        exp_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] del_log[$];

    int pass_cnt = 0, total_cnt = 0;
    int beats_done = 0, disc_left = 0, err_beat = -1, idoff_beat = -1, err_seen = 0;
    bit rsp_en = 0;
    logic exp_id_err = 0;

    // One clock cycle: account for this cycle's handshakes, then drive the next cycle's inputs.
    task automatic tick();
        bit ar_hs, r_hs, inst_hs, pend;
        ar_t a;
        exp_t e;
        #1;
        ar_hs   = o_arvalid && i_arready;
        r_hs    = i_rvalid && o_rready;
        inst_hs = o_inst_valid && i_inst_ready && !i_redirect;
        pend    = o_arvalid && !i_arready;
        if (inst_hs) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL inst_unexpected: got pc %h, want no instruction", o_inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (o_inst_pc !== e.pc || o_inst !== e.data || o_inst_err !== e.err)
                    $display("FAIL inst_payload: got pc %h data %h err %b, want pc %h data %h err %b",
                             o_inst_pc, o_inst, o_inst_err, e.pc, e.data, e.err);
                else pass_cnt++;
                if (e.err) err_seen++;
            end
            del_log.push_back(o_inst_pc);
        end
        if (r_hs && resp_q.size() > 0) begin
            a = resp_q.pop_front();
            beats_done++;
            if (i_rid !== a.id) exp_id_err = 1'b1;
            if (i_redirect) begin
            end else if (disc_left > 0) begin
                disc_left--;
            end else begin
                e.pc = a.addr; e.data = a.addr ^ 32'hA5A5_0000; e.err = (i_rresp != 2'b00);
                exp_q.push_back(e);
            end
        end
        if (ar_hs) begin
            a.addr = o_araddr; a.id = o_arid;
            resp_q.push_back(a);
            ar_log.push_back(o_araddr);
            total_cnt++;
            if (resp_q.size() > MAX_OUT)
                $display("FAIL max_outstanding: got %0d in flight, want at most %0d", resp_q.size(), MAX_OUT);
            else pass_cnt++;
        end
        if (i_redirect) begin
            disc_left = resp_q.size() + int'(pend);
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        i_start = 0; i_halt = 0; i_redirect = 0;
        if (rsp_en && resp_q.size() > 0) begin
            i_rvalid = 1;
            i_rdata  = resp_q[0].addr ^ 32'hA5A5_0000;
            i_rresp  = (beats_done == err_beat) ? 2'b10 : 2'b00;
            i_rid    = resp_q[0].id + ((beats_done == idoff_beat) ? 4'd1 : 4'd0);
        end else begin
            i_rvalid = 0;
            i_rresp  = 2'b00;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rstn = 0;
        i_start = 0; i_halt = 0; i_redirect = 0; i_redirect_pc = '0;
        i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = '0; i_rid = '0; i_inst_ready = 0;
        rsp_en = 0; resp_q.delete(); exp_q.delete(); ar_log.delete(); del_log.delete();
        disc_left = 0; beats_done = 0; exp_id_err = 0; err_beat = -1; idoff_beat = -1;
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if (o_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", o_arvalid); else pass_cnt++;
        total_cnt++; if (o_rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", o_rready); else pass_cnt++;
        total_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b want 0", o_inst_valid); else pass_cnt++;
        total_cnt++; if (o_inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", o_inst); else pass_cnt++;
        total_cnt++; if (o_inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h want 0", o_inst_pc); else pass_cnt++;
        total_cnt++; if (o_inst_err !== 1'b0 || o_id_err !== 1'b0) $display("FAIL rst_err: got %b/%b want 0/0", o_inst_err, o_id_err); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (o_arprot !== 3'b100) $display("FAIL arprot: got %b want 100", o_arprot); else pass_cnt++;
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_stream();
        logic [31:0] want;
        i_arready = 1; rsp_en = 1; i_inst_ready = 1; i_halt = 1;
        run(3);
        total_cnt++; if (o_arvalid !== 1'b0) $display("FAIL halt_in_idle: got arvalid %b want 0", o_arvalid); else pass_cnt++;
        i_start = 1;
        run(30);
        for (int k = 0; k < 10; k++) begin
            want = 32'(k * 4);
            total_cnt++;
            if (k >= ar_log.size()) $display("FAIL stream_addr%0d: got none want %h", k, want);
            else if (ar_log[k] !== want) $display("FAIL stream_addr%0d: got %h want %h", k, ar_log[k], want);
            else pass_cnt++;
        end
        total_cnt++; if (del_log.size() < 20) $display("FAIL stream_count: got %0d want >= 20", del_log.size()); else pass_cnt++;
        i_halt = 1;
        for (int n = 0; n < 20 && (o_busy || o_arvalid); n++) tick();
        run(2);
        total_cnt++; if (o_busy !== 1'b0 || o_arvalid !== 1'b0) $display("FAIL stream_stop: got busy %b arvalid %b want 0/0", o_busy, o_arvalid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] cap_inst, cap_pc;
        i_inst_ready = 0; i_start = 1;
        for (int n = 0; n < 20 && !(resp_q.size() == MAX_OUT && o_inst_valid); n++) tick();
        total_cnt++;
        if (!(resp_q.size() == MAX_OUT && o_inst_valid)) $display("FAIL bp_fill: got %0d in flight valid %b want %0d/1", resp_q.size(), o_inst_valid, MAX_OUT);
        else pass_cnt++;
        cap_inst = o_inst; cap_pc = o_inst_pc;
        for (int n = 0; n < 5; n++) begin
            tick();
            #1;
            total_cnt++; if (o_rready !== 1'b0) $display("FAIL bp_rready: got %b want 0", o_rready); else pass_cnt++;
            total_cnt++; if (o_inst !== cap_inst || o_inst_pc !== cap_pc) $display("FAIL bp_stable: got %h@%h want %h@%h", o_inst, o_inst_pc, cap_inst, cap_pc); else pass_cnt++;
            total_cnt++; if (o_arvalid !== 1'b0) $display("FAIL bp_third_ar: got arvalid %b want 0", o_arvalid); else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        int base;
        i_redirect = 1; i_redirect_pc = 32'h100;
        tick();
        total_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL redir_flush: got valid %b want 0", o_inst_valid); else pass_cnt++;
        total_cnt++; if (disc_left !== 2) $display("FAIL redir_inflight: got %0d old beats want 2", disc_left); else pass_cnt++;
        base = del_log.size();
        i_inst_ready = 1;
        for (int n = 0; n < 20 && del_log.size() < base + 2; n++) tick();
        total_cnt++;
        if (del_log.size() < base + 2) $display("FAIL redir_timeout: got %0d deliveries want 2", del_log.size() - base);
        else if (del_log[base] !== 32'h100 || del_log[base+1] !== 32'h104) $display("FAIL redir_pc: got %h,%h want 00000100,00000104", del_log[base], del_log[base+1]);
        else pass_cnt++;
    endtask

    task automatic test_err_id();
        total_cnt++; if (o_id_err !== 1'b0) $display("FAIL id_err_pre: got %b want 0", o_id_err); else pass_cnt++;
        err_seen = 0;
        err_beat = beats_done + 1;
        idoff_beat = beats_done + 3;
        run(12);
        total_cnt++; if (err_seen !== 1) $display("FAIL rresp_err_count: got %0d err instructions want 1", err_seen); else pass_cnt++;
        total_cnt++; if (o_id_err !== 1'b1 || exp_id_err !== 1'b1) $display("FAIL id_err_set: got %b want 1", o_id_err); else pass_cnt++;
        run(6);
        total_cnt++; if (o_id_err !== 1'b1) $display("FAIL id_err_sticky: got %b want 1", o_id_err); else pass_cnt++;
        err_beat = -1; idoff_beat = -1;
    endtask

    task automatic test_halt_drain();
        int nar;
        rsp_en = 0;
        for (int n = 0; n < 10 && resp_q.size() < MAX_OUT; n++) tick();
        i_halt = 1;
        tick();
        nar = ar_log.size();
        for (int n = 0; n < 4; n++) begin
            tick();
            #1;
            total_cnt++; if (o_arvalid !== 1'b0) $display("FAIL drain_no_ar: got arvalid %b want 0", o_arvalid); else pass_cnt++;
            total_cnt++; if (o_busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", o_busy); else pass_cnt++;
        end
        rsp_en = 1;
        for (int n = 0; n < 10 && o_busy; n++) tick();
        run(3);
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL drain_done: got busy %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (ar_log.size() !== nar || o_arvalid !== 1'b0) $display("FAIL drain_idle: got %0d new ARs arvalid %b want 0/0", ar_log.size() - nar, o_arvalid); else pass_cnt++;
    endtask

    task automatic test_redirect_pending();
        bit found = 0;
        int ar_base, del_base;
        logic [3:0] cap_id;
        apply_reset();
        i_arready = 1; rsp_en = 1; i_inst_ready = 1; i_start = 1;
        for (int n = 0; n < 20 && !found; n++) begin
            if (o_arvalid && o_araddr == 32'h8) found = 1;
            else tick();
        end
        total_cnt++; if (!found) $display("FAIL pend_reach: got no AR at 00000008 want one"); else pass_cnt++;
        i_arready = 0; i_redirect = 1; i_redirect_pc = 32'h100;
        cap_id = o_arid; ar_base = ar_log.size(); del_base = del_log.size();
        for (int n = 0; n < 3; n++) begin
            tick();
            #1;
            total_cnt++;
            if (o_arvalid !== 1'b1 || o_araddr !== 32'h8 || o_arid !== cap_id)
                $display("FAIL pend_hold: got %b %h id %h want 1 00000008 id %h", o_arvalid, o_araddr, o_arid, cap_id);
            else pass_cnt++;
        end
        i_arready = 1;
        for (int n = 0; n < 10 && ar_log.size() < ar_base + 2; n++) tick();
        total_cnt++;
        if (ar_log.size() < ar_base + 2) $display("FAIL pend_ar_timeout: got %0d ARs want 2", ar_log.size() - ar_base);
        else if (ar_log[ar_base] !== 32'h8 || ar_log[ar_base+1] !== 32'h100) $display("FAIL pend_ar_seq: got %h,%h want 00000008,00000100", ar_log[ar_base], ar_log[ar_base+1]);
        else pass_cnt++;
        for (int n = 0; n < 10 && del_log.size() <= del_base; n++) tick();
        total_cnt++;
        if (del_log.size() <= del_base) $display("FAIL pend_del_timeout: got no delivery want pc 00000100");
        else if (del_log[del_base] !== 32'h100) $display("FAIL pend_del_pc: got %h want 00000100", del_log[del_base]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int ar_base, k;
        ar_base = ar_log.size();
        i_redirect = 1; i_redirect_pc = 32'hFFFF_FFF8;
        run(10);
        k = -1;
        for (int i = ar_base; i < ar_log.size() - 1; i++) if (k < 0 && ar_log[i] == 32'hFFFF_FFFC) k = i;
        total_cnt++;
        if (k < 0) $display("FAIL wrap_seen: got no AR at fffffffc want one");
        else if (ar_log[k+1] !== 32'h0) $display("FAIL wrap_next: got %h want 00000000", ar_log[k+1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        rsp_en = 0;
        for (int n = 0; n < 10 && resp_q.size() < MAX_OUT; n++) tick();
        #2 rstn = 0;
        #1;
        total_cnt++;
        if (o_arvalid !== 1'b0 || o_busy !== 1'b0 || o_inst_valid !== 1'b0 || o_rready !== 1'b0)
            $display("FAIL midrst_clear: got arvalid %b busy %b valid %b rready %b want all 0", o_arvalid, o_busy, o_inst_valid, o_rready);
        else pass_cnt++;
        resp_q.delete(); exp_q.delete();
        i_rvalid = 0; i_start = 0; i_redirect = 0;
        @(negedge clk);
        rstn = 1;
        i_rvalid = 1; i_rdata = 32'hDEAD_BEEF; i_rid = 4'd3; i_rresp = 2'b00;
        #1;
        total_cnt++; if (o_rready !== 1'b1) $display("FAIL midrst_rready: got %b want 1", o_rready); else pass_cnt++;
        @(negedge clk);
        i_rvalid = 0;
        #1;
        total_cnt++;
        if (o_inst_valid !== 1'b0 || o_busy !== 1'b0 || o_arvalid !== 1'b0 || o_id_err !== 1'b0)
            $display("FAIL midrst_stray: got valid %b busy %b arvalid %b id_err %b want all 0", o_inst_valid, o_busy, o_arvalid, o_id_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_err_id();
        test_halt_drain();
        test_redirect_pending();
        test_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
